// File: rtl/capture_pkg.sv
// capture_pkg: state encoding and default sizing shared by the capture sequencer files.
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_BURST = 3'd3,
    ST_STOP  = 3'd4
  } cap_state_t;

  localparam int BURST_WORDS_DEF  = 8192;
  localparam int FLUSH_CYCLES_DEF = 16;
  localparam int FIFO_AW_DEF      = 15;

endpackage

// File: rtl/burst_counter.sv
// burst_counter: loadable up-counter with a terminal-count flag (count == limit).
// Used by the sequencer for the flush length, the burst word count and the host-stall watchdog.
module burst_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Count register: load takes priority over increment.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: runs one FX3 capture session (flush, run, bursts, stop) against the sample FIFO.
// Optional build macro: CAPTURE_WATCHDOG_EN adds a host-stall watchdog that flags bufferError when
// dataAvailable sits high in RUN for WATCHDOG_CYCLES cycles without a burst starting.
//
// state  | meaning
// IDLE   | no session; config outputs follow config inputs
// FLUSH  | fifoClear held for FLUSH_CYCLES; bufferError cleared on entry
// RUN    | capture enabled; dataAvailable reflects FIFO fill level
// BURST  | host reading BURST_WORDS words; fifoRead follows readData
// STOP   | capture disabled for one cycle before returning to IDLE
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int BURST_WORDS     = BURST_WORDS_DEF,
  parameter int FIFO_AW         = FIFO_AW_DEF,
  parameter int FLUSH_CYCLES    = FLUSH_CYCLES_DEF,
  parameter int WATCHDOG_CYCLES = 1000000
) (
  input  logic             inclk,
  input  logic             nReset,
  input  logic             collectData,
  input  logic             readData,
  input  logic             testModeIn,
  input  logic             samplingModeIn,
  input  logic             dcOffsetCompIn,
  input  logic [FIFO_AW:0] fifoWords,
  input  logic             fifoEmpty,
  input  logic             fifoOverflow,
  output logic             captureEnable,
  output logic             fifoClear,
  output logic             fifoRead,
  output logic             dataAvailable,
  output logic             bufferError,
  output logic             testMode,
  output logic             samplingMode,
  output logic             dcOffsetComp,
  output logic [2:0]       state
);

  localparam int BCW = $clog2(BURST_WORDS) + 1;
  localparam int FCW = $clog2(FLUSH_CYCLES) + 1;

  localparam logic [FIFO_AW:0] AVAIL_THR  = (FIFO_AW+1)'(BURST_WORDS);
  localparam logic [BCW-1:0]   BURST_LAST = BCW'(BURST_WORDS - 1);
  localparam logic [FCW-1:0]   FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

  cap_state_t state_q, state_d;

  logic collect_r, collect_prev;
  logic flush_tc, word_tc, wd_set;
  logic short_burst, err_set;

  logic capture_en_q, fifo_clear_q, fifo_read_q, data_avail_q, buf_err_q;
  logic capture_en_d, fifo_clear_d, fifo_read_d, data_avail_d, buf_err_d;
  logic test_mode_q, sampling_mode_q, dc_offset_q;

  // Register collectData and keep its previous value for rise detection.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      collect_r    <= 1'b0;
      collect_prev <= 1'b0;
    end else begin
      collect_r    <= collectData;
      collect_prev <= collect_r;
    end
  end

  // Flush length: cleared outside FLUSH, expires on the last flush cycle.
  burst_counter #(.WIDTH(FCW)) u_flush_cnt (
    .clk_sys  (inclk),
    .rst_b    (nReset),
    .load     (state_q != ST_FLUSH),
    .load_val ('0),
    .en       (state_q == ST_FLUSH),
    .limit    (FLUSH_LAST),
    .tc       (flush_tc)
  );

  // Burst word count: zeroed outside BURST, counts each issued read.
  burst_counter #(.WIDTH(BCW)) u_word_cnt (
    .clk_sys  (inclk),
    .rst_b    (nReset),
    .load     (state_q != ST_BURST),
    .load_val ('0),
    .en       ((state_q == ST_BURST) && fifo_read_q),
    .limit    (BURST_LAST),
    .tc       (word_tc)
  );

`ifdef CAPTURE_WATCHDOG_EN
  localparam int WCW = $clog2(WATCHDOG_CYCLES) + 1;
  localparam logic [WCW-1:0] WD_LAST = WCW'(WATCHDOG_CYCLES - 1);

  logic wd_tc;

  // Host-stall timer: restarts on burst entry or outside RUN, saturates at the limit.
  burst_counter #(.WIDTH(WCW)) u_wd_cnt (
    .clk_sys  (inclk),
    .rst_b    (nReset),
    .load     ((state_q != ST_RUN) || (state_d == ST_BURST)),
    .load_val ('0),
    .en       (data_avail_q && !wd_tc),
    .limit    (WD_LAST),
    .tc       (wd_tc)
  );

  assign wd_set = (state_q == ST_RUN) && data_avail_q && wd_tc && (state_d != ST_BURST);
`else
  assign wd_set = 1'b0;
`endif

  // State register.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a burst always runs to completion once started, even if collectData drops.
  always_comb begin
    state_d     = state_q;
    short_burst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (collect_r && !collect_prev) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_tc) state_d = collect_r ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (readData)        state_d = ST_BURST;
        else if (!collect_r) state_d = ST_STOP;
      end
      ST_BURST: begin
        if (fifo_read_q && word_tc) begin
          state_d = collect_r ? ST_RUN : ST_STOP;
        end else if (!readData) begin
          short_burst = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_STOP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight off a flop.
  always_comb begin
    capture_en_d = (state_d == ST_RUN) || (state_d == ST_BURST);
    fifo_clear_d = (state_d == ST_FLUSH);
    fifo_read_d  = (state_d == ST_BURST);
    data_avail_d = (state_d == ST_RUN) && (fifoWords >= AVAIL_THR);
    err_set      = short_burst
                 | (fifo_read_q & fifoEmpty)
                 | (fifoOverflow & (state_q != ST_IDLE))
                 | wd_set;
    // Clearing on FLUSH entry wins over any error raised in the same cycle.
    if ((state_d == ST_FLUSH) && (state_q != ST_FLUSH)) begin
      buf_err_d = 1'b0;
    end else begin
      buf_err_d = buf_err_q | err_set;
    end
  end

  // Output registers; config bits follow the inputs only while idle.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      capture_en_q    <= 1'b0;
      fifo_clear_q    <= 1'b0;
      fifo_read_q     <= 1'b0;
      data_avail_q    <= 1'b0;
      buf_err_q       <= 1'b0;
      test_mode_q     <= 1'b0;
      sampling_mode_q <= 1'b0;
      dc_offset_q     <= 1'b0;
    end else begin
      capture_en_q <= capture_en_d;
      fifo_clear_q <= fifo_clear_d;
      fifo_read_q  <= fifo_read_d;
      data_avail_q <= data_avail_d;
      buf_err_q    <= buf_err_d;
      if (state_q == ST_IDLE) begin
        test_mode_q     <= testModeIn;
        sampling_mode_q <= samplingModeIn;
        dc_offset_q     <= dcOffsetCompIn;
      end
    end
  end

  assign captureEnable = capture_en_q;
  assign fifoClear     = fifo_clear_q;
  assign fifoRead      = fifo_read_q;
  assign dataAvailable = data_avail_q;
  assign bufferError   = buf_err_q;
  assign testMode      = test_mode_q;
  assign samplingMode  = sampling_mode_q;
  assign dcOffsetComp  = dc_offset_q;
  assign state         = state_q;

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Sequences one capture session between the FX3 GPIF interface and the sample FIFO, in the FX3 (80 MHz) clock domain.
- Turns the FX3 `collectData`/`readData` control lines into FIFO clear, capture enable and burst read strobes.
- Latches the configuration bits (test mode, PAL/NTSC, DC offset) only while idle.
- Drives `dataAvailable` and a sticky `bufferError` back to the FX3.

## Interface
Parameters:
- `BURST_WORDS`, 8192: words per FX3 burst; `dataAvailable` threshold.
- `FIFO_AW`, 15: FIFO address width; `fifoWords` is FIFO_AW+1 bits.
- `FLUSH_CYCLES`, 16: cycles `fifoClear` is held at session start.
- `WATCHDOG_CYCLES`, 1000000: host-stall limit (watchdog build only).

Ports:
- `inclk` in 1: FX3 system clock; all logic on rising edge.
- `nReset` in 1: reset is asynchronous and active-low.
- `collectData` in 1: FX3 request to capture.
- `readData` in 1: FX3 burst read in progress.
- `testModeIn`, `samplingModeIn`, `dcOffsetCompIn` in 1 each: raw config bits.
- `fifoWords` in FIFO_AW+1: read-side FIFO fill level.
- `fifoEmpty` in 1: FIFO read side empty.
- `fifoOverflow` in 1: single-cycle write-overflow pulse, already synchronised into `inclk`.
- `captureEnable` out 1: ADC-side writes permitted.
- `fifoClear` out 1: FIFO synchronous clear.
- `fifoRead` out 1: FIFO read strobe.
- `dataAvailable` out 1: at least one burst is ready.
- `bufferError` out 1: sticky error flag.
- `testMode`, `samplingMode`, `dcOffsetComp` out 1 each: latched config.
- `state` out 3: current state, for debug.

## Operation
States: IDLE, FLUSH, RUN, BURST, STOP.
- IDLE
  - All strobes 0.
  - Config outputs track the config inputs every cycle.
  - Rising edge of registered `collectData` -> FLUSH.
- FLUSH
  - `fifoClear`=1 for exactly FLUSH_CYCLES cycles; config frozen.
  - `bufferError` cleared on entry.
  - Counter expiry -> RUN.
  - `collectData` low during FLUSH -> IDLE at counter expiry.
- RUN
  - `captureEnable`=1.
  - `dataAvailable` = (`fifoWords` >= BURST_WORDS), registered.
  - `readData` sampled high -> BURST with word counter = 0.
  - `collectData` low -> STOP.
- BURST
  - `fifoRead`=1 while `readData`=1 and counter < BURST_WORDS; counter increments per read.
  - `dataAvailable` forced 0.
  - Counter reaches BURST_WORDS -> RUN, or STOP if `collectData` is low.
  - `readData` low with counter < BURST_WORDS -> `bufferError`=1, then RUN.
  - `fifoRead` while `fifoEmpty` -> `bufferError`=1; the read is still issued.
- STOP
  - `captureEnable`=0, `dataAvailable`=0.
  - One cycle, then IDLE.
  - `bufferError` holds.

General rules:
- `fifoOverflow` in any state other than IDLE sets `bufferError`. It is ignored in IDLE.
- `bufferError` clears only on FLUSH entry or reset.
- Counter width is clog2(BURST_WORDS)+1. Comparisons are unsigned.

## Timing
- Reset value 0 for every output. `state`=IDLE.
- Reset asserted mid-session drops all outputs immediately (asynchronous). The FIFO is then left uncleared until the next FLUSH.
- All outputs are registered.
- `collectData` rise -> `fifoClear` high 2 cycles later (1 input register + 1 state register).
- `fifoRead` asserts the cycle after `readData` is first sampled high. It deasserts the cycle after the BURST_WORDS-th read or after `readData` is sampled low.
- `dataAvailable` latency from `fifoWords` crossing the threshold: 1 cycle.
- Simultaneous `readData` rise and `collectData` fall in RUN: BURST takes priority; STOP follows burst completion.
- Simultaneous overflow and FLUSH entry: clear wins.

## Configuration
- `CAPTURE_WATCHDOG_EN` defined
  - In RUN, a counter runs while `dataAvailable`=1 with no BURST entry.
  - When it reaches WATCHDOG_CYCLES, `bufferError` is set.
  - The counter resets on BURST entry and on leaving RUN.
- `CAPTURE_WATCHDOG_EN` undefined
  - No watchdog logic.
  - WATCHDOG_CYCLES is unused.

## Structure
- Shared package `capture_pkg`:
  - state enum (IDLE=0, FLUSH=1, RUN=2, BURST=3, STOP=4);
  - default BURST_WORDS, FLUSH_CYCLES and FIFO_AW constants.
- One sub-module, `burst_counter`: loadable up-counter with terminal-count flag, reused for the FLUSH count, burst word count and watchdog.

## Test plan
1. Reset, then raise `collectData` -> `fifoClear`=1 for exactly 16 cycles, then `captureEnable`=1. Config outputs equal the inputs sampled in the final IDLE cycle.
2. In RUN set `fifoWords`=8191 -> `dataAvailable`=0; set 8192 -> `dataAvailable`=1 one cycle later. Hold `readData` high -> `fifoRead` high for exactly 8192 cycles, `dataAvailable`=0 throughout the burst.
3. `readData` drops after 100 reads -> `bufferError`=1 and stays 1 through RUN. Toggle `collectData` low then high -> `bufferError`=0 on FLUSH entry.
4. `fifoOverflow` pulse in RUN -> `bufferError`=1. Same pulse in IDLE -> no change. Toggle `samplingModeIn` in RUN -> `samplingMode` unchanged.
5. Drop `collectData` mid-burst -> burst completes all 8192 reads, then STOP, then IDLE with `captureEnable`=0. Assert `nReset` low mid-burst -> all outputs 0 without waiting for a clock edge.
6. With `CAPTURE_WATCHDOG_EN` defined and WATCHDOG_CYCLES=64, hold `dataAvailable` with no `readData` -> `bufferError` rises on the 64th cycle. Without the macro -> `bufferError` stays 0.
